// File: rtl/vga_pkg.sv
// 640x480@60 VGA timing constants shared by the timing generator.
package vga_pkg;

  localparam int VGA_BIT         = 10;

  localparam int VGA_H_VISIBLE   = 640;
  localparam int VGA_H_FRONT     = 16;
  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_BACK      = 48;
  localparam int VGA_H_TOTAL     = VGA_H_VISIBLE + VGA_H_FRONT
                                 + VGA_H_SYNC + VGA_H_BACK;

  localparam int VGA_V_VISIBLE   = 480;
  localparam int VGA_V_FRONT     = 10;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_BACK      = 33;
  localparam int VGA_V_TOTAL     = VGA_V_VISIBLE + VGA_V_FRONT
                                 + VGA_V_SYNC + VGA_V_BACK;

  localparam int VGA_TICK_FRAMES = 8;

  localparam logic SYNC_ACTIVE   = 1'b0;

endpackage

// File: rtl/vga_timing_wrap_counter.sv
// Enabled up-counter that wraps from MAX to 0; wrap flags the wrapping cycle.
module wrap_counter #(
  parameter int WIDTH = 10,
  parameter int MAX   = 799
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX);

  assign wrap = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/vga_timing.sv
// Free-running 640x480@60 timing generator with registered, zero-skew decode.
// VGA_TICK_EN adds a game_tick pulse every TICK_FRAMES frames.
module vga_timing
  import vga_pkg::*;
#(
  parameter int BIT         = VGA_BIT,
  parameter int H_VISIBLE   = VGA_H_VISIBLE,
  parameter int H_FRONT     = VGA_H_FRONT,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BACK      = VGA_H_BACK,
  parameter int V_VISIBLE   = VGA_V_VISIBLE,
  parameter int V_FRONT     = VGA_V_FRONT,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BACK      = VGA_V_BACK,
  parameter int TICK_FRAMES = VGA_TICK_FRAMES
) (
  input  logic           clk,
  input  logic           rst,
  output logic [BIT-1:0] x_pos,
  output logic [BIT-1:0] y_pos,
  output logic           hsync,
  output logic           vsync,
  output logic           display_on,
  output logic           line_start,
  output logic           frame_start,
  output logic           game_tick
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [BIT-1:0] H_VIS  = BIT'(H_VISIBLE);
  localparam logic [BIT-1:0] HS_BEG = BIT'(H_VISIBLE + H_FRONT);
  localparam logic [BIT-1:0] HS_END = BIT'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [BIT-1:0] V_VIS  = BIT'(V_VISIBLE);
  localparam logic [BIT-1:0] VS_BEG = BIT'(V_VISIBLE + V_FRONT);
  localparam logic [BIT-1:0] VS_END = BIT'(V_VISIBLE + V_FRONT + V_SYNC);

  if (TICK_FRAMES < 1 || TICK_FRAMES > 255) begin : g_bad_tick
    $error("vga_timing: TICK_FRAMES must be 1..255");
  end
  if (H_TOTAL > (1 << BIT) || V_TOTAL > (1 << BIT)) begin : g_bad_bit
    $error("vga_timing: BIT too narrow for totals");
  end

  logic           h_wrap;
  logic           v_wrap;
  logic [BIT-1:0] x_nxt;
  logic [BIT-1:0] y_nxt;
  logic           ls_nxt;
  logic           fs_nxt;

  wrap_counter #(
    .WIDTH (BIT),
    .MAX   (H_TOTAL - 1)
  ) u_h_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .count (x_pos),
    .wrap  (h_wrap)
  );

  wrap_counter #(
    .WIDTH (BIT),
    .MAX   (V_TOTAL - 1)
  ) u_v_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (h_wrap),
    .count (y_pos),
    .wrap  (v_wrap)
  );

  // Decode looks at the values the counters take at this edge, so the
  // registered flags line up with the coordinates they describe.
  always_comb begin
    x_nxt = h_wrap ? '0 : x_pos + BIT'(1);
    y_nxt = y_pos;
    if (v_wrap) begin
      y_nxt = '0;
    end else if (h_wrap) begin
      y_nxt = y_pos + BIT'(1);
    end
    ls_nxt = (x_nxt == '0);
    fs_nxt = ls_nxt && (y_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      display_on  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= (x_nxt >= HS_BEG && x_nxt < HS_END)
                   ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync       <= (y_nxt >= VS_BEG && y_nxt < VS_END)
                   ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      display_on  <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
      line_start  <= ls_nxt;
      frame_start <= fs_nxt;
    end
  end

`ifdef VGA_TICK_EN
  localparam int TW = $clog2(TICK_FRAMES + 1);

  logic [TW-1:0] tick_count_unused;
  logic          tick_wrap;

  // Counting the upcoming frame_start makes the wrap coincide with it.
  wrap_counter #(
    .WIDTH (TW),
    .MAX   (TICK_FRAMES - 1)
  ) u_tick_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (fs_nxt),
    .count (tick_count_unused),
    .wrap  (tick_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      game_tick <= 1'b0;
    end else begin
      game_tick <= tick_wrap;
    end
  end
`else
  assign game_tick = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: full-size and shrunken-geometry instances
// checked every cycle against a pixel-index reference model.
module tb_vga_timing;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
    logic       gt;
  } exp_t;

  localparam int NCYC = 70000;

  // Full-size geometry
  localparam int D_HV = 640, D_HF = 16, D_HS = 96, D_HB = 48;
  localparam int D_VV = 480, D_VF = 10, D_VS = 2,  D_VB = 33;
  localparam int D_TF = 8;
  localparam int D_FT = (D_HV+D_HF+D_HS+D_HB) * (D_VV+D_VF+D_VS+D_VB);

  // Shrunken geometry so many frames fit in the run
  localparam int S_HV = 16, S_HF = 2, S_HS = 4, S_HB = 3;
  localparam int S_VV = 12, S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_TF = 3;
  localparam int S_FT = (S_HV+S_HF+S_HS+S_HB) * (S_VV+S_VF+S_VS+S_VB);

  logic       clk = 1'b0;
  logic       rst_d = 1'b1;
  logic       rst_s = 1'b1;

  logic [9:0] x_d, y_d, x_s, y_s;
  logic       hs_d, vs_d, de_d, ls_d, fs_d, gt_d;
  logic       hs_s, vs_s, de_s, ls_s, fs_s, gt_s;

  int errors = 0;
  int checks = 0;

  exp_t q_d[$];
  exp_t q_s[$];

  int n_ls_d_exp = 0, n_ls_d_got = 0;
  int n_fs_s_exp = 0, n_fs_s_got = 0;
  int n_gt_s_exp = 0, n_gt_s_got = 0;

  always #5 clk = ~clk;

  vga_timing u_dut (
    .clk         (clk),
    .rst         (rst_d),
    .x_pos       (x_d),
    .y_pos       (y_d),
    .hsync       (hs_d),
    .vsync       (vs_d),
    .display_on  (de_d),
    .line_start  (ls_d),
    .frame_start (fs_d),
    .game_tick   (gt_d)
  );

  vga_timing #(
    .BIT         (10),
    .H_VISIBLE   (S_HV),
    .H_FRONT     (S_HF),
    .H_SYNC      (S_HS),
    .H_BACK      (S_HB),
    .V_VISIBLE   (S_VV),
    .V_FRONT     (S_VF),
    .V_SYNC      (S_VS),
    .V_BACK      (S_VB),
    .TICK_FRAMES (S_TF)
  ) u_small (
    .clk         (clk),
    .rst         (rst_s),
    .x_pos       (x_s),
    .y_pos       (y_s),
    .hsync       (hs_s),
    .vsync       (vs_s),
    .display_on  (de_s),
    .line_start  (ls_s),
    .frame_start (fs_s),
    .game_tick   (gt_s)
  );

  // Outputs for a pixel index p counted from the first post-reset pixel.
  function automatic exp_t model(input bit in_rst, input int p,
                                 input bit tick,
                                 input int hv, input int hf, input int hsy,
                                 input int hb, input int vv, input int vf,
                                 input int vsy);
    exp_t e;
    int   ht, x, y;
    ht = hv + hf + hsy + hb;
    x  = p % ht;
    y  = p / ht;
    if (in_rst) begin
      e = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1,
            de: 1'b0, ls: 1'b0, fs: 1'b0, gt: 1'b0};
    end else begin
      e.x  = 10'(x);
      e.y  = 10'(y);
      e.hs = !(x >= hv + hf && x < hv + hf + hsy);
      e.vs = !(y >= vv + vf && y < vv + vf + vsy);
      e.de = (x < hv) && (y < vv);
      e.ls = (x == 0);
      e.fs = (p == 0);
      e.gt = tick;
    end
    return e;
  endfunction

  function automatic bit tick_of(input bit fs, input int frames, input int tf);
`ifdef VGA_TICK_EN
    return fs && (frames % tf == 0);
`else
    return 1'b0;
`endif
  endfunction

  // Stimulus: decide reset for the coming edge, push the expected result.
  initial begin : stim
    int   pd, fd, ps, fsn, rs_left;
    bit   mid_done, t;
    exp_t e;
    pd = 0; fd = 0; ps = 0; fsn = 0; rs_left = 0;
    mid_done = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      // full-size: 3-cycle power-up reset, then one reset at x=700 mid-frame
      if (c < 3) begin
        rst_d = 1'b1;
      end else if (!mid_done && pd >= 40 * 800 && pd % 800 == 700) begin
        rst_d = 1'b1;
        mid_done = 1'b1;
      end else begin
        rst_d = 1'b0;
      end
      if (rst_d) begin
        pd = 0; fd = 0;
        e = model(1'b1, 0, 1'b0, D_HV, D_HF, D_HS, D_HB, D_VV, D_VF, D_VS);
      end else begin
        pd = (pd + 1) % D_FT;
        if (pd == 0) fd++;
        t = tick_of(pd == 0, fd, D_TF);
        e = model(1'b0, pd, t, D_HV, D_HF, D_HS, D_HB, D_VV, D_VF, D_VS);
      end
      if (e.ls) n_ls_d_exp++;
      q_d.push_back(e);

      // shrunken: power-up reset, then rare random resets of 1..3 cycles
      if (c < 3) begin
        rst_s = 1'b1;
      end else if (rs_left > 0) begin
        rst_s = 1'b1;
        rs_left--;
      end else if ($urandom_range(0, 2999) == 0) begin
        rst_s = 1'b1;
        rs_left = $urandom_range(0, 2);
      end else begin
        rst_s = 1'b0;
      end
      if (rst_s) begin
        ps = 0; fsn = 0;
        e = model(1'b1, 0, 1'b0, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS);
      end else begin
        ps = (ps + 1) % S_FT;
        if (ps == 0) fsn++;
        t = tick_of(ps == 0, fsn, S_TF);
        e = model(1'b0, ps, t, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS);
      end
      if (e.fs) n_fs_s_exp++;
      if (e.gt) n_gt_s_exp++;
      q_s.push_back(e);
    end
    @(posedge clk);
    #3;
    checks++;
    if (n_ls_d_got != n_ls_d_exp) begin
      errors++;
      $display("FAIL line_start_count: got %0d want %0d",
               n_ls_d_got, n_ls_d_exp);
    end
    checks++;
    if (n_fs_s_got != n_fs_s_exp) begin
      errors++;
      $display("FAIL frame_start_count: got %0d want %0d",
               n_fs_s_got, n_fs_s_exp);
    end
    checks++;
    if (n_gt_s_got != n_gt_s_exp) begin
      errors++;
      $display("FAIL game_tick_count: got %0d want %0d",
               n_gt_s_got, n_gt_s_exp);
    end
    checks++;
    if (q_d.size() != 0 || q_s.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d left want 0/0",
               q_d.size(), q_s.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Monitor: after every edge pop the expectation and compare.
  always begin : mon
    exp_t e, g;
    @(posedge clk);
    #1;
    if (q_d.size() > 0) begin
      e = q_d.pop_front();
      g = '{x: x_d, y: y_d, hs: hs_d, vs: vs_d,
            de: de_d, ls: ls_d, fs: fs_d, gt: gt_d};
      if (ls_d) n_ls_d_got++;
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL full t=%0t got x=%0d y=%0d hs/vs/de/ls/fs/gt=%b%b%b%b%b%b want x=%0d y=%0d %b%b%b%b%b%b",
                 $time, g.x, g.y, g.hs, g.vs, g.de, g.ls, g.fs, g.gt,
                 e.x, e.y, e.hs, e.vs, e.de, e.ls, e.fs, e.gt);
      end
    end
    if (q_s.size() > 0) begin
      e = q_s.pop_front();
      g = '{x: x_s, y: y_s, hs: hs_s, vs: vs_s,
            de: de_s, ls: ls_s, fs: fs_s, gt: gt_s};
      if (fs_s) n_fs_s_got++;
      if (gt_s) n_gt_s_got++;
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL small t=%0t got x=%0d y=%0d hs/vs/de/ls/fs/gt=%b%b%b%b%b%b want x=%0d y=%0d %b%b%b%b%b%b",
                 $time, g.x, g.y, g.hs, g.vs, g.de, g.ls, g.fs, g.gt,
                 e.x, e.y, e.hs, e.vs, e.de, e.ls, e.fs, e.gt);
      end
    end
  end

endmodule
